// File: rtl/pi_pipeline.sv
// pi_pipeline: four-stage handshaked fixed-point PI controller.
//   S0  latch sample: error = actual - setpoint (one guard bit), latch gains
//   S1  integrator update (clear > hold > accumulate), saturating
//   S2  gain products p = error*kp, i = integrator*ki, each >>> FRAC_BITS
//   S3  sum p + i, saturate to the output range, flag clamping on o_sat
// Optional feature macro: PI_PIPELINE_ANTIWINDUP_EN clamps the integrator to
// +/- i_integral_limit after each accumulate. Without it the limit input is
// ignored and the integrator only saturates at its own signed range.
module pi_pipeline #(
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 32,
    parameter int FRAC_BITS    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic signed [INPUT_WIDTH-1:0]  i_setpoint,
    input  logic signed [INPUT_WIDTH-1:0]  i_actual,
    input  logic signed [INPUT_WIDTH-1:0]  i_kp,
    input  logic signed [INPUT_WIDTH-1:0]  i_ki,
    input  logic                           i_clear,
    input  logic                           i_hold,
    input  logic        [OUTPUT_WIDTH-1:0] i_integral_limit,
    output logic                           o_valid,
    output logic signed [OUTPUT_WIDTH-1:0] o_pi_out,
    output logic signed [OUTPUT_WIDTH-1:0] o_integral,
    output logic                           o_sat
);

    // Error width: one guard bit so actual - setpoint can never overflow.
    localparam int EW = INPUT_WIDTH + 1;
    // Integrator accumulate width: two guard bits over the integrator so the
    // add and the comparison against -limit are both exact.
    localparam int AW = OUTPUT_WIDTH + 2;
    // Full-precision product widths.
    localparam int PW = EW + INPUT_WIDTH;
    localparam int QW = OUTPUT_WIDTH + INPUT_WIDTH;
    // Sum width: one bit above the wider product.
    localparam int SW = ((PW > QW) ? PW : QW) + 1;

    // Signed range limits of an OUTPUT_WIDTH value, in the accumulate and
    // sum widths respectively.
    localparam logic signed [AW-1:0] INT_MAX = AW'({1'b0, {(OUTPUT_WIDTH-1){1'b1}}});
    localparam logic signed [AW-1:0] INT_MIN = ~INT_MAX;
    localparam logic signed [SW-1:0] OUT_MAX = SW'({1'b0, {(OUTPUT_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] OUT_MIN = ~OUT_MAX;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                           s0_valid_q, s0_valid_d;
    logic signed [EW-1:0]           s0_error_q, s0_error_d;
    logic signed [INPUT_WIDTH-1:0]  s0_kp_q,    s0_kp_d;
    logic signed [INPUT_WIDTH-1:0]  s0_ki_q,    s0_ki_d;

    logic                           s1_valid_q, s1_valid_d;
    logic signed [EW-1:0]           s1_error_q, s1_error_d;
    logic signed [INPUT_WIDTH-1:0]  s1_kp_q,    s1_kp_d;
    logic signed [INPUT_WIDTH-1:0]  s1_ki_q,    s1_ki_d;
    logic signed [OUTPUT_WIDTH-1:0] integ_q,    integ_d;

    logic                           s2_valid_q, s2_valid_d;
    logic signed [PW-1:0]           s2_p_q,     s2_p_d;
    logic signed [QW-1:0]           s2_i_q,     s2_i_d;

    logic                           out_valid_q, out_valid_d;
    logic signed [OUTPUT_WIDTH-1:0] out_q,       out_d;
    logic                           sat_q,       sat_d;

    // ------------------------------------------------------------------
    // Combinational intermediates
    // ------------------------------------------------------------------
    logic signed [EW-1:0]           sample_error;
    logic signed [AW-1:0]           integ_sum;
    logic signed [AW-1:0]           integ_lim;
    logic signed [AW-1:0]           integ_sat;
    logic signed [PW-1:0]           p_full;
    logic signed [QW-1:0]           i_full;
    logic signed [SW-1:0]           sum_full;

`ifdef PI_PIPELINE_ANTIWINDUP_EN
    logic signed [AW-1:0]           lim_pos;
    logic signed [AW-1:0]           lim_neg;

    // The limit is an unsigned magnitude; zero-extend before negating.
    assign lim_pos = {2'b00, i_integral_limit};
    assign lim_neg = -lim_pos;
`else
    logic                           unused_limit;

    // The clamp input has no function when anti-windup is compiled out.
    assign unused_limit = ^i_integral_limit;
`endif

    // ------------------------------------------------------------------
    // S0: error and gain capture
    // ------------------------------------------------------------------
    assign sample_error = EW'(i_actual) - EW'(i_setpoint);

    // Latch error and both gains together so a gain change never splits a sample.
    always_comb begin
        s0_valid_d = i_valid;
        s0_error_d = s0_error_q;
        s0_kp_d    = s0_kp_q;
        s0_ki_d    = s0_ki_q;
        if (i_valid) begin
            s0_error_d = sample_error;
            s0_kp_d    = i_kp;
            s0_ki_d    = i_ki;
        end
    end

    // ------------------------------------------------------------------
    // S1: integrator
    // ------------------------------------------------------------------
    assign integ_sum = AW'(integ_q) + AW'(s0_error_q);

    // Optional anti-windup clamp on the raw accumulate result.
    always_comb begin
        integ_lim = integ_sum;
`ifdef PI_PIPELINE_ANTIWINDUP_EN
        if (integ_sum > lim_pos) begin
            integ_lim = lim_pos;
        end else if (integ_sum < lim_neg) begin
            integ_lim = lim_neg;
        end
`endif
    end

    // Final clamp to the integrator's own signed range so it never wraps.
    always_comb begin
        integ_sat = integ_lim;
        if (integ_lim > INT_MAX) begin
            integ_sat = INT_MAX;
        end else if (integ_lim < INT_MIN) begin
            integ_sat = INT_MIN;
        end
    end

    // Integrator next value: clear beats hold beats accumulate.
    always_comb begin
        integ_d = integ_q;
        if (i_clear) begin
            integ_d = '0;
        end else if (i_hold) begin
            integ_d = integ_q;
        end else if (s0_valid_q) begin
            integ_d = integ_sat[OUTPUT_WIDTH-1:0];
        end
    end

    // Carry the error and gains alongside the freshly updated integrator.
    always_comb begin
        s1_valid_d = s0_valid_q;
        s1_error_d = s1_error_q;
        s1_kp_d    = s1_kp_q;
        s1_ki_d    = s1_ki_q;
        if (s0_valid_q) begin
            s1_error_d = s0_error_q;
            s1_kp_d    = s0_kp_q;
            s1_ki_d    = s0_ki_q;
        end
    end

    // ------------------------------------------------------------------
    // S2: gain products. integ_q here is the value written by the sample now
    // in S1, so each sample multiplies its own post-update integrator.
    // ------------------------------------------------------------------
    assign p_full = PW'(s1_error_q) * PW'(s1_kp_q);
    assign i_full = QW'(integ_q) * QW'(s1_ki_q);

    // Scale each product by the gain fixed-point position (floor rounding).
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_p_d     = s2_p_q;
        s2_i_d     = s2_i_q;
        if (s1_valid_q) begin
            s2_p_d = p_full >>> FRAC_BITS;
            s2_i_d = i_full >>> FRAC_BITS;
        end
    end

    // ------------------------------------------------------------------
    // S3: saturating sum
    // ------------------------------------------------------------------
    assign sum_full = SW'(s2_p_q) + SW'(s2_i_q);

    // Result and clamp flag only change on a valid slot; otherwise they hold.
    always_comb begin
        out_valid_d = s2_valid_q;
        out_d       = out_q;
        sat_d       = sat_q;
        if (s2_valid_q) begin
            if (sum_full > OUT_MAX) begin
                out_d = OUT_MAX[OUTPUT_WIDTH-1:0];
                sat_d = 1'b1;
            end else if (sum_full < OUT_MIN) begin
                out_d = OUT_MIN[OUTPUT_WIDTH-1:0];
                sat_d = 1'b1;
            end else begin
                out_d = sum_full[OUTPUT_WIDTH-1:0];
                sat_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers; reset flushes every in-flight sample immediately.
    // ------------------------------------------------------------------
    // Pipeline and integrator flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_error_q  <= '0;
            s0_kp_q     <= '0;
            s0_ki_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_error_q  <= '0;
            s1_kp_q     <= '0;
            s1_ki_q     <= '0;
            integ_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_p_q      <= '0;
            s2_i_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_error_q  <= s0_error_d;
            s0_kp_q     <= s0_kp_d;
            s0_ki_q     <= s0_ki_d;
            s1_valid_q  <= s1_valid_d;
            s1_error_q  <= s1_error_d;
            s1_kp_q     <= s1_kp_d;
            s1_ki_q     <= s1_ki_d;
            integ_q     <= integ_d;
            s2_valid_q  <= s2_valid_d;
            s2_p_q      <= s2_p_d;
            s2_i_q      <= s2_i_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            sat_q       <= sat_d;
        end
    end

    assign o_valid    = out_valid_q;
    assign o_pi_out   = out_q;
    assign o_integral = integ_q;
    assign o_sat      = sat_q;

endmodule

// File: tb/tb_pi_pipeline.sv
// tb_pi_pipeline: directed vectors with hand-computed expectations for
// pi_pipeline. A second instance with FRAC_BITS=4 shares the stimulus and is
// only checked in the fractional-gain stream.
module tb_pi_pipeline;

    localparam int IW = 18;
    localparam int OW = 32;
    localparam longint OMAX = 64'sd2147483647;
    localparam longint OMIN = -64'sd2147483648;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_valid;
    logic signed [IW-1:0]  i_setpoint;
    logic signed [IW-1:0]  i_actual;
    logic signed [IW-1:0]  i_kp;
    logic signed [IW-1:0]  i_ki;
    logic                  i_clear;
    logic                  i_hold;
    logic        [OW-1:0]  i_integral_limit;
    logic                  o_valid;
    logic signed [OW-1:0]  o_pi_out;
    logic signed [OW-1:0]  o_integral;
    logic                  o_sat;
    logic                  f_valid;
    logic signed [OW-1:0]  f_pi_out;
    logic signed [OW-1:0]  f_integral;
    logic                  f_sat;

    int vectors     = 0;
    int miscompares = 0;

    // Stream description: per-sample operands, controls and expectations.
    int                    n_s;
    bit                    chk_f;
    logic signed [IW-1:0]  s_sp [8];
    logic signed [IW-1:0]  s_ac [8];
    logic signed [IW-1:0]  s_kp [8];
    logic signed [IW-1:0]  s_ki [8];
    bit                    s_hold [8];
    bit                    s_clr [8];
    longint                e_int [8];
    longint                e_out [8];
    longint                e_fout [8];
    bit                    e_sat [8];

    always #5 clk = ~clk;

    pi_pipeline #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .FRAC_BITS   (0)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .i_setpoint      (i_setpoint),
        .i_actual        (i_actual),
        .i_kp            (i_kp),
        .i_ki            (i_ki),
        .i_clear         (i_clear),
        .i_hold          (i_hold),
        .i_integral_limit(i_integral_limit),
        .o_valid         (o_valid),
        .o_pi_out        (o_pi_out),
        .o_integral      (o_integral),
        .o_sat           (o_sat)
    );

    pi_pipeline #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .FRAC_BITS   (4)
    ) u_frac (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .i_setpoint      (i_setpoint),
        .i_actual        (i_actual),
        .i_kp            (i_kp),
        .i_ki            (i_ki),
        .i_clear         (i_clear),
        .i_hold          (i_hold),
        .i_integral_limit(i_integral_limit),
        .o_valid         (f_valid),
        .o_pi_out        (f_pi_out),
        .o_integral      (f_integral),
        .o_sat           (f_sat)
    );

    task check_vec(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task step();
        @(posedge clk);
        #1;
    endtask

    task new_stream(input int n);
        n_s   = n;
        chk_f = 1'b0;
        for (int j = 0; j < 8; j++) begin
            s_hold[j] = 1'b0;
            s_clr[j]  = 1'b0;
            e_sat[j]  = 1'b0;
            e_fout[j] = 0;
        end
    endtask

    task set_s(input int j, input int sp, input int ac, input int kp, input int ki,
               input longint ei, input longint eo);
        s_sp[j]  = IW'(sp);
        s_ac[j]  = IW'(ac);
        s_kp[j]  = IW'(kp);
        s_ki[j]  = IW'(ki);
        e_int[j] = ei;
        e_out[j] = eo;
    endtask

    task do_clear();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check_vec("clear_int", o_integral, 0);
    endtask

    // Apply the stream back-to-back. Sample j is accepted at edge j; its
    // integrator update (and hold/clear) happens at edge j+1, its result at j+3.
    task run_stream(input string name);
        for (int t = 0; t <= n_s + 3; t++) begin
            i_valid = (t < n_s);
            if (t < n_s) begin
                i_setpoint = s_sp[t];
                i_actual   = s_ac[t];
                i_kp       = s_kp[t];
                i_ki       = s_ki[t];
            end
            i_hold  = (t >= 1 && t - 1 < n_s) ? s_hold[t-1] : 1'b0;
            i_clear = (t >= 1 && t - 1 < n_s) ? s_clr[t-1]  : 1'b0;
            step();
            if (t >= 1 && t - 1 < n_s)
                check_vec({name, "_int"}, o_integral, e_int[t-1]);
            if (t >= 3 && t - 3 < n_s) begin
                check_vec({name, "_valid"}, o_valid, 1);
                check_vec({name, "_out"}, o_pi_out, e_out[t-3]);
                check_vec({name, "_sat"}, o_sat, e_sat[t-3]);
                if (chk_f) begin
                    check_vec({name, "_fvalid"}, f_valid, 1);
                    check_vec({name, "_fout"}, f_pi_out, e_fout[t-3]);
                end
            end else begin
                check_vec({name, "_idle"}, o_valid, 0);
            end
        end
        i_valid = 1'b0;
        i_hold  = 1'b0;
        i_clear = 1'b0;
        $display("stream %s: %0d samples applied", name, n_s);
    endtask

    initial begin
        int pulses;
        rst              = 1'b1;
        i_valid          = 1'b0;
        i_setpoint       = '0;
        i_actual         = '0;
        i_kp             = '0;
        i_ki             = '0;
        i_clear          = 1'b0;
        i_hold           = 1'b0;
        i_integral_limit = 32'hFFFF_FFFF;

        // Reset state.
        repeat (3) step();
        check_vec("rst_valid", o_valid, 0);
        check_vec("rst_out", o_pi_out, 0);
        check_vec("rst_int", o_integral, 0);
        check_vec("rst_sat", o_sat, 0);
        rst = 1'b0;
        step();
        $display("reset released");

        // Single sample: error 10, kp 2, ki 3 -> integ 10, out 20+30.
        new_stream(1);
        set_s(0, 100, 110, 2, 3, 10, 50);
        run_stream("single");

        // Back-to-back: integ 10,20,30 -> out 50,80,110.
        do_clear();
        new_stream(3);
        for (int j = 0; j < 3; j++) set_s(j, 100, 110, 2, 3, 10 * (j + 1), 20 + 30 * (j + 1));
        run_stream("b2b");

        // Hold on the 2nd sample's update edge, clear on the 3rd's.
        do_clear();
        new_stream(3);
        set_s(0, 100, 110, 2, 3, 10, 50);
        set_s(1, 100, 110, 2, 3, 10, 50);
        set_s(2, 100, 110, 2, 3, 0, 20);
        s_hold[1] = 1'b1;
        s_clr[2]  = 1'b1;
        run_stream("clrhold");

        // Output saturation in both directions.
        do_clear();
        new_stream(2);
        set_s(0, -131072, 131071, 131071, 0, 262143, OMAX);
        set_s(1, 131071, -131072, 131071, 0, 0, OMIN);
        e_sat[0] = 1'b1;
        e_sat[1] = 1'b1;
        run_stream("outsat");
        repeat (2) step();
        check_vec("outsat_hold_out", o_pi_out, OMIN);
        check_vec("outsat_hold_sat", o_sat, 1);

        // Integrator limit, positive then negative error.
        i_integral_limit = 32'd25;
        do_clear();
        new_stream(4);
`ifdef PI_PIPELINE_ANTIWINDUP_EN
        set_s(0, 0, 10, 0, 1, 10, 10);
        set_s(1, 0, 10, 0, 1, 20, 20);
        set_s(2, 0, 10, 0, 1, 25, 25);
        set_s(3, 0, 10, 0, 1, 25, 25);
`else
        for (int j = 0; j < 4; j++) set_s(j, 0, 10, 0, 1, 10 * (j + 1), 10 * (j + 1));
`endif
        run_stream("aw_pos");
        do_clear();
        new_stream(4);
`ifdef PI_PIPELINE_ANTIWINDUP_EN
        set_s(0, 10, 0, 0, 1, -10, -10);
        set_s(1, 10, 0, 0, 1, -20, -20);
        set_s(2, 10, 0, 0, 1, -25, -25);
        set_s(3, 10, 0, 0, 1, -25, -25);
`else
        for (int j = 0; j < 4; j++) set_s(j, 10, 0, 0, 1, -10 * (j + 1), -10 * (j + 1));
`endif
        run_stream("aw_neg");
        i_integral_limit = 32'hFFFF_FFFF;

        // Fractional gains: FRAC_BITS=4 instance checked alongside.
        do_clear();
        new_stream(3);
        chk_f = 1'b1;
        set_s(0, 0, 3, 32, 0, 3, 96);
        set_s(1, 0, -3, 32, 0, 0, -96);
        set_s(2, 0, -1, 8, 0, -1, -8);
        e_fout[0] = 6;
        e_fout[1] = -6;
        e_fout[2] = -1;
        run_stream("frac");

        // Mid-stream reset with three samples in flight.
        do_clear();
        for (int t = 0; t < 3; t++) begin
            i_valid    = 1'b1;
            i_setpoint = 18'sd100;
            i_actual   = 18'sd110;
            i_kp       = 18'sd2;
            i_ki       = 18'sd3;
            step();
        end
        check_vec("pre_rst_int", o_integral, 20);
        #2;
        rst = 1'b1;
        #1;
        check_vec("midrst_valid", o_valid, 0);
        check_vec("midrst_out", o_pi_out, 0);
        check_vec("midrst_int", o_integral, 0);
        check_vec("midrst_sat", o_sat, 0);
        i_valid = 1'b0;
        step();
        rst = 1'b0;
        pulses = 0;
        for (int t = 0; t < 6; t++) begin
            step();
            if (o_valid === 1'b1) pulses++;
        end
        check_vec("midrst_no_valid", pulses, 0);
        check_vec("midrst_int_after", o_integral, 0);
        $display("mid-stream reset applied");

        // Integrator full-range saturation, positive then negative.
        i_valid    = 1'b1;
        i_kp       = '0;
        i_ki       = '0;
        i_setpoint = -18'sd131072;
        i_actual   = 18'sd131071;
        repeat (8200) step();
        i_valid = 1'b0;
        repeat (4) step();
        check_vec("intsat_pos", o_integral, OMAX);
        check_vec("intsat_pos_out", o_pi_out, 0);
        i_valid    = 1'b1;
        i_setpoint = 18'sd131071;
        i_actual   = -18'sd131072;
        repeat (16400) step();
        i_valid = 1'b0;
        repeat (4) step();
        check_vec("intsat_neg", o_integral, OMIN);
        $display("integrator range saturation applied");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
